// File: rtl/sync_ram_pipe_if.sv
// Signal bundle for sync_ram_pipe: always-accepted byte-enable write port,
// handshaked read request, handshaked read response and sticky range flag.
interface sync_ram_pipe_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    rd_valid;
    logic                    rd_ready;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic                    err_oob;

    modport master (
        output wr_addr, wr_strb, wr_data, rd_valid, rd_addr, resp_ready,
        input  rd_ready, resp_valid, resp_data, err_oob
    );

    modport slave (
        input  wr_addr, wr_strb, wr_data, rd_valid, rd_addr, resp_ready,
        output rd_ready, resp_valid, resp_data, err_oob
    );
endinterface

// File: rtl/sync_ram_pipe.sv
// Byte-addressed single-bank RAM with byte-enable writes, a READ_LATENCY-deep
// read pipeline and a credit-guarded fall-through response FIFO so the
// response consumer may stall without any read data being lost.
module sync_ram_pipe #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 1 << (ADDR_WIDTH - $clog2(DATA_WIDTH / 8)),
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    parameter     MEM_HEX      = ""
) (
    input  logic           clock,
    input  logic           reset,
    sync_ram_pipe_if.slave bus
);
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(BYTES);
    localparam int IDX_W      = ADDR_WIDTH - OFF_W;
    localparam int MEM_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FIFO_DEPTH = READ_LATENCY + 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CRD_W      = $clog2(FIFO_DEPTH + 1);

    // Merge new bytes into an old word wherever the strobe is set.
    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BYTES-1:0]      strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int b = 0; b < BYTES; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

    // FIFO pointer advance with wrap at a non-power-of-two depth.
    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_wr_en;
    logic                  w_wr_oob;
    logic                  w_rd_oob;
    logic                  w_rd_acc;
    logic                  w_rdw_hit;
    logic [DATA_WIDTH-1:0] w_old_word;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_unused_ofs;

    logic [DATA_WIDTH-1:0] r_data_p [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_vld_p;
    logic                  w_last_vld;
    logic [DATA_WIDTH-1:0] w_last_data;

    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CRD_W-1:0]      r_count;
    logic [CRD_W-1:0]      r_credits;
    logic                  r_err;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_resp_hs;

    // Byte offset bits never select anything; misalignment is silently ignored.
    assign w_unused_ofs = ^{bus.wr_addr[OFF_W-1:0], bus.rd_addr[OFF_W-1:0]};

    assign w_wr_idx  = bus.wr_addr[ADDR_WIDTH-1:OFF_W];
    assign w_rd_idx  = bus.rd_addr[ADDR_WIDTH-1:OFF_W];
    assign w_wr_en   = |bus.wr_strb;
    assign w_wr_oob  = 32'(w_wr_idx) >= DEPTH;
    assign w_rd_oob  = 32'(w_rd_idx) >= DEPTH;
    assign w_rd_acc  = bus.rd_valid && (r_credits != '0);
    assign w_rdw_hit = w_wr_en && !w_wr_oob && (w_wr_idx == w_rd_idx);

    // Out-of-range reads return zero; in new-data mode a colliding write is forwarded.
    assign w_old_word = w_rd_oob ? '0 : r_mem[w_rd_idx[MEM_IDX_W-1:0]];
    assign w_rd_word  = ((RDW_MODE != 0) && w_rdw_hit)
                      ? f_merge(w_old_word, bus.wr_data, bus.wr_strb)
                      : w_old_word;

    // Byte-enable array write; out-of-range writes are dropped.
    always_ff @(posedge clock) begin
        if (w_wr_en && !w_wr_oob) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.wr_strb[b]) r_mem[w_wr_idx[MEM_IDX_W-1:0]][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
            end
        end
    end

    // ---- stage 1: array read at accept edge; stages 2..L: plain delay ----
    // Read data pipeline (no reset; qualified by r_vld_p).
    always_ff @(posedge clock) begin
        r_data_p[0] <= w_rd_word;
        for (int s = 1; s < READ_LATENCY; s++) r_data_p[s] <= r_data_p[s-1];
    end

    // Valid bits travelling alongside the read data; reset drops in-flight reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= w_rd_acc;
            for (int s = 1; s < READ_LATENCY; s++) r_vld_p[s] <= r_vld_p[s-1];
        end
    end

    // ---- last stage -> fall-through response FIFO ----
    assign w_last_vld   = r_vld_p[READ_LATENCY-1];
    assign w_last_data  = r_data_p[READ_LATENCY-1];
    assign w_fifo_empty = (r_count == '0);
    assign w_resp_hs    = bus.resp_valid && bus.resp_ready;
    // With an empty FIFO and a ready consumer the last stage bypasses straight out.
    assign w_push       = w_last_vld && !(w_fifo_empty && bus.resp_ready);
    assign w_pop        = !w_fifo_empty && bus.resp_ready;

    // FIFO storage (no reset; occupancy tracked by r_count).
    always_ff @(posedge clock) begin
        if (w_push) r_fifo[r_wptr] <= w_last_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= f_ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= f_ptr_inc(r_rptr);
            if (w_push && !w_pop)      r_count <= r_count + CRD_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CRD_W'(1);
        end
    end

    // Credits bound pipeline plus FIFO occupancy to FIFO_DEPTH, so the FIFO never overflows.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_credits <= CRD_W'(FIFO_DEPTH);
        end else if (w_rd_acc && !w_resp_hs) begin
            r_credits <= r_credits - CRD_W'(1);
        end else if (!w_rd_acc && w_resp_hs) begin
            r_credits <= r_credits + CRD_W'(1);
        end
    end

    // Sticky out-of-range flag for dropped writes and accepted out-of-range reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((w_wr_en && w_wr_oob) || (w_rd_acc && w_rd_oob)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.rd_ready   = (r_credits != '0);
    assign bus.resp_valid = !w_fifo_empty || w_last_vld;
    assign bus.resp_data  = !w_fifo_empty ? r_fifo[r_rptr]
                          : (w_last_vld ? w_last_data : '0);
    assign bus.err_oob    = r_err;
endmodule

// File: tb/tb_sync_ram_pipe.sv
// Directed bench for sync_ram_pipe: three instances (L=1 old-data/DEPTH=256,
// L=3 new-data, L=2 old-data) driven from one table of per-cycle records,
// plus a hand-written asynchronous-reset sequence.
module tb_sync_ram_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_ram_pipe_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus0 ();
    sync_ram_pipe_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus1 ();
    sync_ram_pipe_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus2 ();

    sync_ram_pipe #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256),
                    .READ_LATENCY(1), .RDW_MODE(0)) u0 (.clock(clk), .reset(rst), .bus(bus0));
    sync_ram_pipe #(.ADDR_WIDTH(12), .DATA_WIDTH(32),
                    .READ_LATENCY(3), .RDW_MODE(1)) u1 (.clock(clk), .reset(rst), .bus(bus1));
    sync_ram_pipe #(.ADDR_WIDTH(12), .DATA_WIDTH(32),
                    .READ_LATENCY(2), .RDW_MODE(0)) u2 (.clock(clk), .reset(rst), .bus(bus2));

    typedef struct {
        int          dut;
        logic [3:0]  strb;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        rv;
        logic [11:0] ra;
        logic        rr;
        logic        e_rdy;
        logic        e_rv;
        logic [31:0] e_d;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];
    int   n_run  = 0;
    int   n_fail = 0;

    logic        s_rdy, s_rv, s_err;
    logic [31:0] s_dat;
    int          lat;

    localparam logic [31:0] B0 = 32'hB000_0040, B1 = 32'hB000_0044,
                            B2 = 32'hB000_0048, B3 = 32'hB000_004C;

    task automatic add(int dut, logic [3:0] strb, logic [11:0] wa, logic [31:0] wd,
                       logic rv, logic [11:0] ra, logic rr,
                       logic e_rdy, logic e_rv, logic [31:0] e_d, logic e_err);
        vec_t v;
        v.dut = dut; v.strb = strb; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.rr = rr;
        v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_d = e_d; v.e_err = e_err;
        tbl.push_back(v);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_all();
        bus0.wr_strb = '0; bus0.wr_addr = '0; bus0.wr_data = '0;
        bus0.rd_valid = 1'b0; bus0.rd_addr = '0; bus0.resp_ready = 1'b1;
        bus1.wr_strb = '0; bus1.wr_addr = '0; bus1.wr_data = '0;
        bus1.rd_valid = 1'b0; bus1.rd_addr = '0; bus1.resp_ready = 1'b1;
        bus2.wr_strb = '0; bus2.wr_addr = '0; bus2.wr_data = '0;
        bus2.rd_valid = 1'b0; bus2.rd_addr = '0; bus2.resp_ready = 1'b1;
    endtask

    task automatic drive(vec_t v);
        idle_all();
        case (v.dut)
            0: begin
                bus0.wr_strb = v.strb; bus0.wr_addr = v.wa; bus0.wr_data = v.wd;
                bus0.rd_valid = v.rv; bus0.rd_addr = v.ra; bus0.resp_ready = v.rr;
            end
            1: begin
                bus1.wr_strb = v.strb; bus1.wr_addr = v.wa; bus1.wr_data = v.wd;
                bus1.rd_valid = v.rv; bus1.rd_addr = v.ra; bus1.resp_ready = v.rr;
            end
            default: begin
                bus2.wr_strb = v.strb; bus2.wr_addr = v.wa; bus2.wr_data = v.wd;
                bus2.rd_valid = v.rv; bus2.rd_addr = v.ra; bus2.resp_ready = v.rr;
            end
        endcase
    endtask

    task automatic sample(int d, output logic rdy, output logic rv,
                          output logic [31:0] dat, output logic err);
        case (d)
            0:       begin rdy = bus0.rd_ready; rv = bus0.resp_valid; dat = bus0.resp_data; err = bus0.err_oob; end
            1:       begin rdy = bus1.rd_ready; rv = bus1.resp_valid; dat = bus1.resp_data; err = bus1.err_oob; end
            default: begin rdy = bus2.rd_ready; rv = bus2.resp_valid; dat = bus2.resp_data; err = bus2.err_oob; end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_all();

        // u0: L=1, old-data RDW, DEPTH=256 (word index 0x100 is out of range).
        //   dut strb   wa      wd            rv ra      rr  rdy rv  data          err
        add(0, 4'hF, 12'h010, 32'hDEADBEEF, 0, 12'h000, 1,  1,  0, 32'h0,         0);
        add(0, 4'h1, 12'h010, 32'h000000AA, 0, 12'h000, 1,  1,  0, 32'h0,         0);
        add(0, 4'h0, 12'h000, 32'h0,        1, 12'h010, 1,  1,  0, 32'h0,         0);
        add(0, 4'hF, 12'h020, 32'hCAFEF00D, 0, 12'h000, 1,  1,  1, 32'hDEADBEAA,  0);
        add(0, 4'hF, 12'h020, 32'h11223344, 1, 12'h023, 1,  1,  0, 32'h0,         0);
        add(0, 4'hF, 12'h000, 32'h12345678, 0, 12'h000, 1,  1,  1, 32'hCAFEF00D,  0);
        add(0, 4'h0, 12'h000, 32'h0,        1, 12'h021, 1,  1,  0, 32'h0,         0);
        add(0, 4'hF, 12'h400, 32'h00000055, 0, 12'h000, 1,  1,  1, 32'h11223344,  0);
        add(0, 4'h0, 12'h000, 32'h0,        1, 12'h400, 1,  1,  0, 32'h0,         1);
        add(0, 4'h0, 12'h000, 32'h0,        1, 12'h000, 1,  1,  1, 32'h0,         1);
        add(0, 4'h0, 12'h000, 32'h0,        0, 12'h000, 1,  1,  1, 32'h12345678,  1);
        add(0, 4'h0, 12'h000, 32'h0,        0, 12'h000, 1,  1,  0, 32'h0,         1);

        // u1: L=3, new-data RDW; back-to-back reads, forwarding, write after accept.
        add(1, 4'hF, 12'h000, 32'hA0A0A0A0, 0, 12'h000, 1,  1,  0, 32'h0,         0);
        add(1, 4'hF, 12'h004, 32'hA1A1A1A1, 0, 12'h000, 1,  1,  0, 32'h0,         0);
        add(1, 4'hF, 12'h008, 32'hA2A2A2A2, 0, 12'h000, 1,  1,  0, 32'h0,         0);
        add(1, 4'hF, 12'h00C, 32'hA3A3A3A3, 0, 12'h000, 1,  1,  0, 32'h0,         0);
        add(1, 4'hF, 12'h020, 32'hCAFEF00D, 0, 12'h000, 1,  1,  0, 32'h0,         0);
        add(1, 4'h0, 12'h000, 32'h0,        1, 12'h000, 1,  1,  0, 32'h0,         0);
        add(1, 4'h0, 12'h000, 32'h0,        1, 12'h004, 1,  1,  0, 32'h0,         0);
        add(1, 4'h0, 12'h000, 32'h0,        1, 12'h008, 1,  1,  0, 32'h0,         0);
        add(1, 4'h0, 12'h000, 32'h0,        1, 12'h00C, 1,  1,  1, 32'hA0A0A0A0,  0);
        add(1, 4'hF, 12'h020, 32'h11223344, 1, 12'h020, 1,  1,  1, 32'hA1A1A1A1,  0);
        add(1, 4'hF, 12'h020, 32'h99999999, 0, 12'h000, 1,  1,  1, 32'hA2A2A2A2,  0);
        add(1, 4'h3, 12'h020, 32'h0000BEEF, 1, 12'h020, 1,  1,  1, 32'hA3A3A3A3,  0);
        add(1, 4'h0, 12'h000, 32'h0,        0, 12'h000, 1,  1,  1, 32'h11223344,  0);
        add(1, 4'h0, 12'h000, 32'h0,        0, 12'h000, 1,  1,  0, 32'h0,         0);
        add(1, 4'h0, 12'h000, 32'h0,        0, 12'h000, 1,  1,  1, 32'h9999BEEF,  0);
        add(1, 4'h0, 12'h000, 32'h0,        0, 12'h000, 1,  1,  0, 32'h0,         0);

        // u2: L=2, consumer stalled -> three accepts then rd_ready low, then drain.
        add(2, 4'hF, 12'h040, B0,           0, 12'h000, 1,  1,  0, 32'h0,         0);
        add(2, 4'hF, 12'h044, B1,           0, 12'h000, 1,  1,  0, 32'h0,         0);
        add(2, 4'hF, 12'h048, B2,           0, 12'h000, 1,  1,  0, 32'h0,         0);
        add(2, 4'hF, 12'h04C, B3,           0, 12'h000, 1,  1,  0, 32'h0,         0);
        add(2, 4'h0, 12'h000, 32'h0,        1, 12'h040, 0,  1,  0, 32'h0,         0);
        add(2, 4'h0, 12'h000, 32'h0,        1, 12'h044, 0,  1,  0, 32'h0,         0);
        add(2, 4'h0, 12'h000, 32'h0,        1, 12'h048, 0,  1,  1, B0,            0);
        add(2, 4'h0, 12'h000, 32'h0,        1, 12'h04C, 0,  0,  1, B0,            0);
        add(2, 4'h0, 12'h000, 32'h0,        1, 12'h04C, 0,  0,  1, B0,            0);
        add(2, 4'h0, 12'h000, 32'h0,        1, 12'h04C, 1,  0,  1, B0,            0);
        add(2, 4'h0, 12'h000, 32'h0,        1, 12'h04C, 1,  1,  1, B1,            0);
        add(2, 4'h0, 12'h000, 32'h0,        0, 12'h000, 1,  1,  1, B2,            0);
        add(2, 4'h0, 12'h000, 32'h0,        0, 12'h000, 1,  1,  1, B3,            0);
        add(2, 4'h0, 12'h000, 32'h0,        0, 12'h000, 1,  1,  0, 32'h0,         0);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Each record: check outputs of the current cycle, then apply its inputs.
        for (int i = 0; i < tbl.size(); i++) begin
            sample(tbl[i].dut, s_rdy, s_rv, s_dat, s_err);
            chk($sformatf("u%0d row%0d rd_ready",   tbl[i].dut, i), 32'(s_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("u%0d row%0d resp_valid", tbl[i].dut, i), 32'(s_rv),  32'(tbl[i].e_rv));
            chk($sformatf("u%0d row%0d resp_data",  tbl[i].dut, i), s_dat,      tbl[i].e_d);
            chk($sformatf("u%0d row%0d err_oob",    tbl[i].dut, i), 32'(s_err), 32'(tbl[i].e_err));
            drive(tbl[i]);
            @(negedge clk);
        end

        // Async reset with two reads in flight and one queued in the FIFO (u2).
        idle_all();
        bus2.resp_ready = 1'b0;
        bus2.rd_valid = 1'b1; bus2.rd_addr = 12'h040; @(negedge clk);
        bus2.rd_addr = 12'h044;                       @(negedge clk);
        bus2.rd_addr = 12'h048;                       @(negedge clk);
        bus2.rd_valid = 1'b0;
        chk("u2 pre-reset resp_valid", 32'(bus2.resp_valid), 32'd1);
        chk("u2 pre-reset resp_data",  bus2.resp_data, B0);
        chk("u0 err_oob sticky",       32'(bus0.err_oob), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("u2 reset resp_valid", 32'(bus2.resp_valid), 32'd0);
        chk("u2 reset resp_data",  bus2.resp_data, 32'h0);
        chk("u2 reset rd_ready",   32'(bus2.rd_ready), 32'd1);
        chk("u0 reset err_oob",    32'(bus0.err_oob), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus2.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("u2 post-reset idle%0d resp_valid", k), 32'(bus2.resp_valid), 32'd0);
            chk($sformatf("u2 post-reset idle%0d rd_ready", k),   32'(bus2.rd_ready),   32'd1);
            @(negedge clk);
        end

        // Array contents survive reset; first response arrives after two edges.
        bus2.rd_valid = 1'b1; bus2.rd_addr = 12'h044;
        @(negedge clk);
        bus2.rd_valid = 1'b0;
        lat = 0;
        while (!bus2.resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("u2 post-reset latency", 32'(lat), 32'd1);
        chk("u2 post-reset data",    bus2.resp_data, B1);
        @(negedge clk);
        chk("u2 post-reset drained", 32'(bus2.resp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
